id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline stage sitting directly downstream of the main control decoder.
- Registers the decoder's control word with the decoded operands, then presents them to EX.
- Detects load-use hazards: stalls the front end and inserts a bubble.
- Applies branch flushes and downstream holds.

Parameters:
- DATA_W, 32, width of register operands, immediate and PC+4.
- REG_W, 5, width of register specifiers.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_RegWrite, id_RegDst, id_ALUSrc, id_Branch, id_MemWrite, id_MemRead, id_MemToReg  in  1 each  decoder control outputs
- id_ALUOp  in  2  decoder ALU op class
- id_uses_rt  in  1  instruction reads rt as a source (R-type, BEQ, SW)
- id_rs, id_rt, id_rd  in  REG_W each  register specifiers
- id_a, id_b  in  DATA_W each  register file read data
- id_imm  in  DATA_W  sign-extended immediate
- id_pc4  in  DATA_W  PC+4
- flush  in  1  branch taken in EX/MEM; kill the instruction in ID
- ex_hold  in  1  downstream not ready; freeze this stage
- stall  out  1  hold PC and IF/ID (combinational)
- ex_valid  out  1  EX slot holds a real instruction
- ex_RegWrite .. ex_MemToReg  out  1 each  registered control
- ex_ALUOp  out  2  registered ALU op class
- ex_rs, ex_rt, ex_rd  out  REG_W each  registered specifiers
- ex_a, ex_b, ex_imm, ex_pc4  out  DATA_W each  registered data

Behaviour:
- Reset (reset=0, asynchronous): every ex_* output is 0 and ex_valid=0.
  - stall is 0 while reset is asserted.
  - With HAZARD_STATS_EN defined, both counters are also 0.
- Hazard (combinational): hazard = ex_valid & ex_MemRead & (ex_rt != 0) & id_valid & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt))).
- stall = ex_hold | (hazard & ~flush).
- Register update on each rising edge, first matching row wins:
  1. ex_hold=1: all ex_* hold their values, including ex_valid.
  2. flush=1: load a bubble. A bubble is ex_valid=0, all control bits 0, ex_ALUOp=00; data and specifier fields are don't-care and are loaded with 0.
  3. hazard=1: load a bubble. The ID instruction is retained upstream by stall and re-evaluated next cycle.
  4. Otherwise: capture all id_* fields, with ex_valid=id_valid.
- When id_valid=0, control bits are captured as 0, whatever the decoder drives.
  - This masks decoder default-case outputs, including its undriven MemRead.
- Latency: one cycle from ID to EX.
  - A load-use pair costs exactly one bubble. Cycle after the bubble: hazard is 0, because ex_MemRead=0.
- Simultaneous events:
  - flush with hazard: flush wins and stall=0, since the ID instruction is dead.
  - ex_hold with flush: hold wins. flush must be held by its source until ex_hold drops.
- Register 0 never causes a hazard.
- Reset mid-stall: outputs clear immediately. Operation resumes normally on the first edge after reset releases.
- x values on don't-care decoder outputs (RegDst, MemToReg for SW/BEQ) pass through unmodified. Verification must not check them for those ops.

Optional Feature:
- Macro HAZARD_STATS_EN.
- Defined:
  - Adds outputs bubble_cnt (32) and flush_cnt (32).
  - bubble_cnt increments on each edge where row 3 applies.
  - flush_cnt increments on each edge where row 2 applies.
  - Neither counter increments while ex_hold=1. Both wrap from 0xFFFFFFFF to 0. Both reset to 0.
- Undefined: the ports and logic are absent. Behaviour is otherwise identical.

Test Plan:
- Reset release, then R-type add: id_rs=1, id_rt=2, id_rd=3, id_a=5, id_b=7, id_valid=1 -> next edge ex_RegWrite=1, ex_RegDst=1, ex_ALUOp=10, ex_a=5, ex_b=7, ex_rd=3, ex_valid=1, stall=0.
- LW with rt=8 in EX, then ID add with rs=8 -> stall=1 for one cycle; next edge EX holds a bubble (ex_valid=0, ex_RegWrite=0); following edge captures the add and stall=0. With HAZARD_STATS_EN, bubble_cnt=1.
- LW with rt=0 in EX, then ID rs=0 -> no stall. LW rt=9, then ID ADDI rt=9 with id_uses_rt=0 and rs=4 -> no stall.
- LW hazard cycle with flush=1 -> stall=0, bubble loaded; with HAZARD_STATS_EN, flush_cnt=1 and bubble_cnt unchanged.
- ex_hold=1 for 3 cycles with a valid SW in EX and new ID data -> ex_* unchanged and stall=1 throughout; on release the new ID instruction is captured.
- Assert reset mid-hazard (with LW in EX) -> ex_valid=0 and stall=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: registers the decoder control word and decoded
// operands for EX, detects load-use hazards (stall + bubble), and applies
// branch flushes and downstream holds.
//
// Optional feature macro: HAZARD_STATS_EN adds the bubble_cnt/flush_cnt
// event counters.
//
// Ports:
//   clock, reset          rising-edge clock, async active-low reset
//   id_*                  decoder control, specifiers and operand data from ID
//   flush                 branch taken downstream; kill the ID instruction
//   ex_hold               downstream not ready; freeze this stage
//   stall                 combinational: hold PC and IF/ID
//   ex_*                  registered control/specifiers/data presented to EX
//   bubble_cnt, flush_cnt (HAZARD_STATS_EN only) event counters
module id_ex_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              id_valid,
  input  logic              id_RegWrite,
  input  logic              id_RegDst,
  input  logic              id_ALUSrc,
  input  logic              id_Branch,
  input  logic              id_MemWrite,
  input  logic              id_MemRead,
  input  logic              id_MemToReg,
  input  logic [1:0]        id_ALUOp,
  input  logic              id_uses_rt,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic [DATA_W-1:0] id_a,
  input  logic [DATA_W-1:0] id_b,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic              flush,
  input  logic              ex_hold,
  output logic              stall,
  output logic              ex_valid,
  output logic              ex_RegWrite,
  output logic              ex_RegDst,
  output logic              ex_ALUSrc,
  output logic              ex_Branch,
  output logic              ex_MemWrite,
  output logic              ex_MemRead,
  output logic              ex_MemToReg,
  output logic [1:0]        ex_ALUOp,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_rd,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc4
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]       bubble_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  localparam int unsigned CNT_W = 32;

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              reg_dst;
    logic              alu_src;
    logic              branch;
    logic              mem_write;
    logic              mem_read;
    logic              mem_to_reg;
    logic [1:0]        alu_op;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc4;
  } stage_t;

  stage_t stage_d, stage_q;
  logic   hazard;

  // Load in EX whose destination feeds a source of the ID instruction.
  always_comb begin
    hazard = stage_q.valid & stage_q.mem_read & (stage_q.rt != '0) & id_valid &
             ((stage_q.rt == id_rs) | (id_uses_rt & (stage_q.rt == id_rt)));
    // Gated by reset so the front end is never frozen while the stage is held in reset.
    stall  = reset & (ex_hold | (hazard & ~flush));
  end

  // Next-state: hold, then bubble (flush or hazard), else capture ID.
  always_comb begin
    stage_d = stage_q;
    if (ex_hold) begin
      stage_d = stage_q;
    end else if (flush || hazard) begin
      stage_d = '0;
    end else begin
      // Control is masked by id_valid so decoder default-case outputs never leak.
      stage_d.valid      = id_valid;
      stage_d.reg_write  = id_valid & id_RegWrite;
      stage_d.reg_dst    = id_valid & id_RegDst;
      stage_d.alu_src    = id_valid & id_ALUSrc;
      stage_d.branch     = id_valid & id_Branch;
      stage_d.mem_write  = id_valid & id_MemWrite;
      stage_d.mem_read   = id_valid & id_MemRead;
      stage_d.mem_to_reg = id_valid & id_MemToReg;
      stage_d.alu_op     = id_valid ? id_ALUOp : 2'b00;
      stage_d.rs         = id_rs;
      stage_d.rt         = id_rt;
      stage_d.rd         = id_rd;
      stage_d.a          = id_a;
      stage_d.b          = id_b;
      stage_d.imm        = id_imm;
      stage_d.pc4        = id_pc4;
    end
  end

  // Stage register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign ex_valid    = stage_q.valid;
  assign ex_RegWrite = stage_q.reg_write;
  assign ex_RegDst   = stage_q.reg_dst;
  assign ex_ALUSrc   = stage_q.alu_src;
  assign ex_Branch   = stage_q.branch;
  assign ex_MemWrite = stage_q.mem_write;
  assign ex_MemRead  = stage_q.mem_read;
  assign ex_MemToReg = stage_q.mem_to_reg;
  assign ex_ALUOp    = stage_q.alu_op;
  assign ex_rs       = stage_q.rs;
  assign ex_rt       = stage_q.rt;
  assign ex_rd       = stage_q.rd;
  assign ex_a        = stage_q.a;
  assign ex_b        = stage_q.b;
  assign ex_imm      = stage_q.imm;
  assign ex_pc4      = stage_q.pc4;

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;

  // Count bubble sources only on edges that actually load a bubble; wraps naturally.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (!ex_hold) begin
      if (flush) begin
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end else if (hazard) begin
        bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign flush_cnt  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: a sequential table of directed
// vectors (inputs, expected stall before the edge, expected EX state after
// the edge) plus hand-written reset sequences.
module tb_id_ex_stage;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;

  // Control order: {RegWrite, RegDst, ALUSrc, Branch, MemWrite, MemRead, MemToReg}
  localparam logic [6:0] C_RTYPE = 7'b1100000;
  localparam logic [6:0] C_LW    = 7'b1010011;
  localparam logic [6:0] C_SW    = 7'b0010100;
  localparam logic [6:0] C_ADDI  = 7'b1010000;
  localparam logic [6:0] C_BEQ   = 7'b0001000;

  typedef struct packed {
    logic              valid;
    logic [6:0]        ctrl;
    logic [1:0]        aluop;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc4;
  } ex_t;

  typedef struct {
    string name;
    ex_t   id;
    logic  uses_rt;
    logic  flush;
    logic  hold;
    logic  exp_stall;
    ex_t   exp;
  } vec_t;

  logic              clock, reset;
  logic              id_valid, id_RegWrite, id_RegDst, id_ALUSrc, id_Branch;
  logic              id_MemWrite, id_MemRead, id_MemToReg, id_uses_rt;
  logic [1:0]        id_ALUOp;
  logic [REG_W-1:0]  id_rs, id_rt, id_rd;
  logic [DATA_W-1:0] id_a, id_b, id_imm, id_pc4;
  logic              flush, ex_hold, stall;
  logic              ex_valid, ex_RegWrite, ex_RegDst, ex_ALUSrc, ex_Branch;
  logic              ex_MemWrite, ex_MemRead, ex_MemToReg;
  logic [1:0]        ex_ALUOp;
  logic [REG_W-1:0]  ex_rs, ex_rt, ex_rd;
  logic [DATA_W-1:0] ex_a, ex_b, ex_imm, ex_pc4;
`ifdef HAZARD_STATS_EN
  logic [31:0]       bubble_cnt, flush_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  id_ex_stage #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clock(clock), .reset(reset),
    .id_valid(id_valid), .id_RegWrite(id_RegWrite), .id_RegDst(id_RegDst),
    .id_ALUSrc(id_ALUSrc), .id_Branch(id_Branch), .id_MemWrite(id_MemWrite),
    .id_MemRead(id_MemRead), .id_MemToReg(id_MemToReg), .id_ALUOp(id_ALUOp),
    .id_uses_rt(id_uses_rt), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_a(id_a), .id_b(id_b), .id_imm(id_imm), .id_pc4(id_pc4),
    .flush(flush), .ex_hold(ex_hold), .stall(stall),
    .ex_valid(ex_valid), .ex_RegWrite(ex_RegWrite), .ex_RegDst(ex_RegDst),
    .ex_ALUSrc(ex_ALUSrc), .ex_Branch(ex_Branch), .ex_MemWrite(ex_MemWrite),
    .ex_MemRead(ex_MemRead), .ex_MemToReg(ex_MemToReg), .ex_ALUOp(ex_ALUOp),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_pc4(ex_pc4)
`ifdef HAZARD_STATS_EN
    , .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  ex_t act;
  assign act = '{valid: ex_valid,
                 ctrl: {ex_RegWrite, ex_RegDst, ex_ALUSrc, ex_Branch, ex_MemWrite, ex_MemRead, ex_MemToReg},
                 aluop: ex_ALUOp, rs: ex_rs, rt: ex_rt, rd: ex_rd,
                 a: ex_a, b: ex_b, imm: ex_imm, pc4: ex_pc4};

  vec_t vecs[$];

  function automatic ex_t mk(logic v, logic [6:0] c, logic [1:0] op, int rs, int rt, int rd,
                             int a, int b, int imm, int pc4);
    ex_t e;
    e.valid = v; e.ctrl = c; e.aluop = op;
    e.rs = REG_W'(rs); e.rt = REG_W'(rt); e.rd = REG_W'(rd);
    e.a = DATA_W'(a); e.b = DATA_W'(b); e.imm = DATA_W'(imm); e.pc4 = DATA_W'(pc4);
    return e;
  endfunction

  task automatic add_vec(string name, ex_t id, logic uses_rt, logic fl, logic hd,
                         logic exp_stall, ex_t exp);
    vec_t v;
    v.name = name; v.id = id; v.uses_rt = uses_rt; v.flush = fl; v.hold = hd;
    v.exp_stall = exp_stall; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic drive(ex_t id, logic uses_rt, logic fl, logic hd);
    id_valid = id.valid;
    {id_RegWrite, id_RegDst, id_ALUSrc, id_Branch, id_MemWrite, id_MemRead, id_MemToReg} = id.ctrl;
    id_ALUOp = id.aluop; id_uses_rt = uses_rt;
    id_rs = id.rs; id_rt = id.rt; id_rd = id.rd;
    id_a = id.a; id_b = id.b; id_imm = id.imm; id_pc4 = id.pc4;
    flush = fl; ex_hold = hd;
  endtask

  task automatic check_bit(string name, logic actual, logic expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, actual, expected);
    end
  endtask

  task automatic check_ex(string name, ex_t expected);
    checks++;
    if (act !== expected) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, expected);
    end
  endtask

`ifdef HAZARD_STATS_EN
  task automatic check_cnt(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask
`endif

  ex_t add1, lw8, add8, lw0, add0, lw9, addi9, lw9b, beq9, lw10, add10, junk, junk_exp;
  ex_t sw1, add345, lw11, add11, lw12, add12;

  initial begin
    // Instruction payloads used by the table.
    add1   = mk(1, C_RTYPE, 2'b10, 1, 2, 3, 5, 7, 0, 32'h104);
    lw8    = mk(1, C_LW,    2'b00, 1, 8, 0, 100, 0, 4, 32'h108);
    add8   = mk(1, C_RTYPE, 2'b10, 8, 2, 4, 11, 12, 0, 32'h10c);
    lw0    = mk(1, C_LW,    2'b00, 3, 0, 0, 200, 0, 8, 32'h110);
    add0   = mk(1, C_RTYPE, 2'b10, 0, 0, 6, 0, 0, 0, 32'h114);
    lw9    = mk(1, C_LW,    2'b00, 2, 9, 0, 300, 0, 12, 32'h118);
    addi9  = mk(1, C_ADDI,  2'b00, 4, 9, 0, 40, 41, 16, 32'h11c);
    lw9b   = mk(1, C_LW,    2'b00, 4, 9, 0, 400, 0, 20, 32'h120);
    beq9   = mk(1, C_BEQ,   2'b01, 1, 9, 0, 50, 51, 32'hfffffffc, 32'h124);
    lw10   = mk(1, C_LW,    2'b00, 0, 10, 0, 0, 0, 24, 32'h128);
    add10  = mk(1, C_RTYPE, 2'b10, 10, 1, 7, 60, 61, 0, 32'h12c);
    junk   = mk(0, 7'b1111111, 2'b00, 10, 10, 6, 70, 71, 72, 32'h130);
    junk_exp = mk(0, 7'b0000000, 2'b00, 10, 10, 6, 70, 71, 72, 32'h130);
    sw1    = mk(1, C_SW,    2'b00, 1, 2, 0, 80, 81, 28, 32'h134);
    add345 = mk(1, C_RTYPE, 2'b10, 3, 4, 5, 90, 91, 0, 32'h138);
    lw11   = mk(1, C_LW,    2'b00, 0, 11, 0, 0, 0, 32, 32'h13c);
    add11  = mk(1, C_RTYPE, 2'b10, 11, 3, 8, 1, 2, 0, 32'h140);
    lw12   = mk(1, C_LW,    2'b00, 0, 12, 0, 0, 0, 36, 32'h144);
    add12  = mk(1, C_RTYPE, 2'b10, 12, 3, 9, 3, 4, 0, 32'h148);

    //        name              id      rt fl hd stall expected EX after edge
    add_vec("rtype_add",       add1,   1, 0, 0, 0, add1);
    add_vec("lw_rt8",          lw8,    0, 0, 0, 0, lw8);
    add_vec("loaduse_bubble",  add8,   1, 0, 0, 1, '0);
    add_vec("after_bubble",    add8,   1, 0, 0, 0, add8);
    add_vec("lw_rt0",          lw0,    0, 0, 0, 0, lw0);
    add_vec("r0_no_hazard",    add0,   1, 0, 0, 0, add0);
    add_vec("lw_rt9",          lw9,    0, 0, 0, 0, lw9);
    add_vec("addi_no_rt_use",  addi9,  0, 0, 0, 0, addi9);
    add_vec("lw_rt9_again",    lw9b,   0, 0, 0, 0, lw9b);
    add_vec("beq_rt_hazard",   beq9,   1, 0, 0, 1, '0);
    add_vec("beq_captured",    beq9,   1, 0, 0, 0, beq9);
    add_vec("lw_rt10",         lw10,   0, 0, 0, 0, lw10);
    add_vec("flush_beats_haz", add10,  1, 1, 0, 0, '0);
    add_vec("invalid_masked",  junk,   1, 0, 0, 0, junk_exp);
    add_vec("sw_captured",     sw1,    1, 0, 0, 0, sw1);
    add_vec("hold_1",          add345, 1, 0, 1, 1, sw1);
    add_vec("hold_2",          add345, 1, 0, 1, 1, sw1);
    add_vec("hold_3",          add345, 1, 0, 1, 1, sw1);
    add_vec("hold_release",    add345, 1, 0, 0, 0, add345);
    add_vec("lw_rt11",         lw11,   0, 0, 0, 0, lw11);
    add_vec("hold_over_flush", add11,  1, 1, 1, 1, lw11);
    add_vec("flush_after_hold",add11,  1, 1, 0, 0, '0);

    // Reset asserted with hold high: EX clear and stall gated off.
    reset = 1'b0;
    drive(add1, 1'b1, 1'b0, 1'b1);
    #3;
    check_ex("reset_ex_zero", '0);
    check_bit("reset_stall", stall, 1'b0);
`ifdef HAZARD_STATS_EN
    check_cnt("reset_bubble_cnt", bubble_cnt, 32'd0);
    check_cnt("reset_flush_cnt", flush_cnt, 32'd0);
`endif
    repeat (2) @(posedge clock);
    #1;
    check_ex("reset_ex_held_zero", '0);
    @(negedge clock);
    reset = 1'b1;
    ex_hold = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clock);
      drive(vecs[i].id, vecs[i].uses_rt, vecs[i].flush, vecs[i].hold);
      #1;
      check_bit({vecs[i].name, "_stall"}, stall, vecs[i].exp_stall);
      @(posedge clock);
      #1;
      check_ex({vecs[i].name, "_ex"}, vecs[i].exp);
`ifdef HAZARD_STATS_EN
      if (vecs[i].name == "loaduse_bubble") check_cnt("bubble_cnt_first", bubble_cnt, 32'd1);
`endif
    end

`ifdef HAZARD_STATS_EN
    check_cnt("bubble_cnt_total", bubble_cnt, 32'd2);
    check_cnt("flush_cnt_total", flush_cnt, 32'd2);
`endif

    // Reset asserted mid-hazard clears EX and stall without a clock edge.
    @(negedge clock);
    drive(lw12, 1'b0, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    check_ex("lw12_captured", lw12);
    @(negedge clock);
    drive(add12, 1'b1, 1'b0, 1'b0);
    #1;
    check_bit("pre_reset_stall", stall, 1'b1);
    #1;
    reset = 1'b0;
    #1;
    check_ex("midreset_ex_zero", '0);
    check_bit("midreset_stall", stall, 1'b0);
    ex_hold = 1'b1;
    #1;
    check_bit("midreset_hold_stall", stall, 1'b0);
`ifdef HAZARD_STATS_EN
    check_cnt("midreset_bubble_cnt", bubble_cnt, 32'd0);
    check_cnt("midreset_flush_cnt", flush_cnt, 32'd0);
`endif

    // Release reset: the add now sees no load in EX and is captured.
    @(negedge clock);
    reset = 1'b1;
    drive(add12, 1'b1, 1'b0, 1'b0);
    #1;
    check_bit("post_reset_stall", stall, 1'b0);
    @(posedge clock);
    #1;
    check_ex("post_reset_capture", add12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

endmodule
